// File: rtl/i2c_regfile_pkg.sv
// Shared types and constants for the I2C pointer/auto-increment register file.
package i2c_regfile_pkg;

  typedef enum logic {
    PTR  = 1'b0,
    DATA = 1'b1
  } rf_state_t;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/i2c_regfile_mem.sv
// DEPTH x 8 register array: one write port, combinational pointer read, registered user read.
module i2c_regfile_mem
  import i2c_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  localparam int DEPTH = depth_of(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [ADDR_WIDTH-1:0] ptr_addr,
  output logic [7:0]            ptr_rdata,
  input  logic [ADDR_WIDTH-1:0] user_addr,
  output logic [7:0]            user_rdata
);

  logic [DEPTH-1:0][7:0] regs;

  // user read samples the array before this edge's write lands, so a
  // same-cycle write/read to one address returns the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs       <= '0;
      user_rdata <= '0;
    end else begin
      if (we) regs[waddr] <= wdata;
      user_rdata <= regs[user_addr];
    end
  end

  assign ptr_rdata = regs[ptr_addr];

endmodule

// File: rtl/i2c_slave_regfile.sv
// Pointer/auto-increment register device behind an i2c_slave byte stream.
// Optional I2C_REGFILE_WRITE_PROTECT_EN adds a per-register write mask.
module i2c_slave_regfile
  import i2c_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  localparam int DEPTH = depth_of(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef I2C_REGFILE_WRITE_PROTECT_EN
  input  logic [DEPTH-1:0]      wp_mask,
`endif
  input  logic [7:0]            s_axis_data_tdata,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  input  logic                  s_axis_data_tlast,
  output logic [7:0]            m_axis_data_tdata,
  output logic                  m_axis_data_tvalid,
  input  logic                  m_axis_data_tready,
  output logic                  m_axis_data_tlast,
  input  logic [ADDR_WIDTH-1:0] user_addr,
  output logic [7:0]            user_rdata,
  output logic                  wr_pulse,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data
);

  rf_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  full_q, full_d;
  logic                  rdy_q;
  logic [7:0]            odata_q;
  logic [7:0]            ptr_rdata;
  logic                  accept, rd_hs, wr_en, prot;

  assign accept = s_axis_data_tvalid & rdy_q;
  assign rd_hs  = full_q & m_axis_data_tready;

`ifdef I2C_REGFILE_WRITE_PROTECT_EN
  assign prot = wp_mask[ptr_q];
`else
  assign prot = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PTR;
    else        state_q <= state_d;
  end

  // a write accept takes priority over a read handshake; both empty the output register
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    full_d  = full_q;
    wr_en   = 1'b0;
    if (accept) begin
      full_d = 1'b0;
      if (state_q == PTR) begin
        ptr_d   = s_axis_data_tdata[ADDR_WIDTH-1:0];
        state_d = s_axis_data_tlast ? PTR : DATA;
      end else begin
        wr_en = ~prot;
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (s_axis_data_tlast) state_d = PTR;
      end
    end else if (rd_hs) begin
      ptr_d  = ptr_q + ADDR_WIDTH'(1);
      full_d = 1'b0;
    end else if (!full_q) begin
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q    <= 1'b0;
      ptr_q    <= '0;
      full_q   <= 1'b0;
      odata_q  <= '0;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      rdy_q    <= 1'b1;
      ptr_q    <= ptr_d;
      full_q   <= full_d;
      if (!full_q && full_d) odata_q <= ptr_rdata;
      wr_pulse <= wr_en;
      if (wr_en) begin
        wr_addr <= ptr_q;
        wr_data <= s_axis_data_tdata;
      end
    end
  end

  i2c_regfile_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (wr_en),
    .waddr      (ptr_q),
    .wdata      (s_axis_data_tdata),
    .ptr_addr   (ptr_q),
    .ptr_rdata  (ptr_rdata),
    .user_addr  (user_addr),
    .user_rdata (user_rdata)
  );

  assign s_axis_data_tready = rdy_q;
  assign m_axis_data_tvalid = full_q;
  assign m_axis_data_tdata  = odata_q;
  assign m_axis_data_tlast  = &ptr_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile (ADDR_WIDTH=4).
module tb_i2c_slave_regfile;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       s_tlast = 1'b0;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b0;
  logic       m_tlast;
  logic [3:0] user_addr = '0;
  logic [7:0] user_rdata;
  logic       wr_pulse;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
`ifdef I2C_REGFILE_WRITE_PROTECT_EN
  logic [15:0] wp_mask = '0;
`endif

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  i2c_slave_regfile #(.ADDR_WIDTH(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
`ifdef I2C_REGFILE_WRITE_PROTECT_EN
    .wp_mask            (wp_mask),
`endif
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .s_axis_data_tlast  (s_tlast),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
    .m_axis_data_tlast  (m_tlast),
    .user_addr          (user_addr),
    .user_rdata         (user_rdata),
    .wr_pulse           (wr_pulse),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data)
  );

  task automatic write_byte(input logic [7:0] d, input logic last);
    @(negedge clk);
    s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic user_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    user_addr = a;
    @(posedge clk); #1;
    d = user_rdata;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !m_tvalid; i++) @(negedge clk);
    total++; if (m_tvalid !== 1'b1) $display("FAIL rd_timeout got tvalid=%b exp 1", m_tvalid); else pass_cnt++;
  endtask

  task automatic read_byte(output logic [7:0] d, output logic l);
    @(negedge clk);
    wait_valid();
    d = m_tdata; l = m_tlast;
    m_tready = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    total++; if ({s_tready, m_tvalid, m_tlast, wr_pulse} !== 4'b0) $display("FAIL rst_flags got %b exp 0000", {s_tready, m_tvalid, m_tlast, wr_pulse}); else pass_cnt++;
    total++; if ({m_tdata, user_rdata, wr_data, wr_addr} !== 28'h0) $display("FAIL rst_data got %h exp 0", {m_tdata, user_rdata, wr_data, wr_addr}); else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    total++; if (s_tready !== 1'b1) $display("FAIL rel_tready got %b exp 1", s_tready); else pass_cnt++;
    total++; if ({m_tvalid, m_tdata} !== 9'h100) $display("FAIL rel_prefetch got %h exp 100", {m_tvalid, m_tdata}); else pass_cnt++;
  endtask

  task automatic test_write();
    logic [7:0] d;
    write_byte(8'h03, 1'b0);
    total++; if (wr_pulse !== 1'b0) $display("FAIL wr_ptr_nopulse got %b exp 0", wr_pulse); else pass_cnt++;
    write_byte(8'hAA, 1'b0);
    total++; if ({wr_pulse, wr_addr, wr_data} !== 13'h1_3_AA) $display("FAIL wr_first got %h exp 13AA", {wr_pulse, wr_addr, wr_data}); else pass_cnt++;
    write_byte(8'hBB, 1'b1);
    total++; if ({wr_pulse, wr_addr, wr_data} !== 13'h1_4_BB) $display("FAIL wr_second got %h exp 14BB", {wr_pulse, wr_addr, wr_data}); else pass_cnt++;
    user_read(4'd3, d);
    total++; if (d !== 8'hAA) $display("FAIL wr_reg3 got %h exp aa", d); else pass_cnt++;
    user_read(4'd4, d);
    total++; if (d !== 8'hBB) $display("FAIL wr_reg4 got %h exp bb", d); else pass_cnt++;
  endtask

  task automatic test_read();
    logic [7:0] d;
    logic l;
    logic [7:0] exp_b;
    // FSM returned to PTR, so this byte only sets the pointer
    write_byte(8'h05, 1'b1);
    total++; if (wr_pulse !== 1'b0) $display("FAIL rd_ptronly_pulse got %b exp 0", wr_pulse); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      read_byte(d, l);
      total++; if (d !== 8'h00) $display("FAIL rd_zero%0d got %h exp 00", i, d); else pass_cnt++;
    end
    write_byte(8'h05, 1'b0);
    write_byte(8'h11, 1'b0);
    write_byte(8'h22, 1'b0);
    write_byte(8'h33, 1'b1);
    write_byte(8'h05, 1'b1);
    for (int i = 0; i < 3; i++) begin
      exp_b = 8'h11 * 8'(i + 1);
      read_byte(d, l);
      total++; if (d !== exp_b) $display("FAIL rd_data%0d got %h exp %h", i, d, exp_b); else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    logic l;
    write_byte(8'h0F, 1'b0);
    write_byte(8'h01, 1'b0);
    write_byte(8'h02, 1'b1);
    total++; if ({wr_addr, wr_data} !== 12'h0_02) $display("FAIL wrap_wraddr got %h exp 002", {wr_addr, wr_data}); else pass_cnt++;
    user_read(4'd15, d);
    total++; if (d !== 8'h01) $display("FAIL wrap_reg15 got %h exp 01", d); else pass_cnt++;
    user_read(4'd0, d);
    total++; if (d !== 8'h02) $display("FAIL wrap_reg0 got %h exp 02", d); else pass_cnt++;
    write_byte(8'hFF, 1'b1);  // upper bits ignored: pointer 15
    read_byte(d, l);
    total++; if ({l, d} !== 9'h101) $display("FAIL wrap_last15 got %h exp 101", {l, d}); else pass_cnt++;
    read_byte(d, l);
    total++; if ({l, d} !== 9'h002) $display("FAIL wrap_last0 got %h exp 002", {l, d}); else pass_cnt++;
  endtask

  task automatic test_collision();
    write_byte(8'h0A, 1'b0);
    write_byte(8'h5A, 1'b0);
    write_byte(8'h6B, 1'b1);
    write_byte(8'h08, 1'b1);
    @(negedge clk);
    wait_valid();
    // write-side pointer (0x0A) must beat the read increment (8 -> 9)
    s_tvalid = 1'b1; s_tdata = 8'h0A; s_tlast = 1'b1; m_tready = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    total++; if (m_tvalid !== 1'b0) $display("FAIL coll_empty got %b exp 0", m_tvalid); else pass_cnt++;
    @(posedge clk); #1;
    total++; if ({m_tvalid, m_tdata} !== 9'h15A) $display("FAIL coll_reload got %h exp 15a", {m_tvalid, m_tdata}); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    write_byte(8'h02, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    total++; if ({s_tready, m_tvalid, m_tlast, wr_pulse} !== 4'b0) $display("FAIL mrst_flags got %b exp 0000", {s_tready, m_tvalid, m_tlast, wr_pulse}); else pass_cnt++;
    total++; if ({m_tdata, user_rdata, wr_data, wr_addr} !== 28'h0) $display("FAIL mrst_data got %h exp 0", {m_tdata, user_rdata, wr_data, wr_addr}); else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    write_byte(8'h07, 1'b0);
    total++; if (wr_pulse !== 1'b0) $display("FAIL mrst_ptr_pulse got %b exp 0", wr_pulse); else pass_cnt++;
    write_byte(8'h99, 1'b1);
    total++; if ({wr_pulse, wr_addr, wr_data} !== 13'h1_7_99) $display("FAIL mrst_write got %h exp 1799", {wr_pulse, wr_addr, wr_data}); else pass_cnt++;
    user_read(4'd3, d);
    total++; if (d !== 8'h00) $display("FAIL mrst_cleared got %h exp 00", d); else pass_cnt++;
  endtask

`ifdef I2C_REGFILE_WRITE_PROTECT_EN
  task automatic test_write_protect();
    logic [7:0] d;
    write_byte(8'h02, 1'b0);
    write_byte(8'h77, 1'b1);
    wp_mask = 16'h0004;
    write_byte(8'h02, 1'b0);
    write_byte(8'h55, 1'b0);
    total++; if (wr_pulse !== 1'b0) $display("FAIL wp_nopulse got %b exp 0", wr_pulse); else pass_cnt++;
    write_byte(8'h66, 1'b1);
    total++; if ({wr_pulse, wr_addr, wr_data} !== 13'h1_3_66) $display("FAIL wp_pulse got %h exp 1366", {wr_pulse, wr_addr, wr_data}); else pass_cnt++;
    user_read(4'd2, d);
    total++; if (d !== 8'h77) $display("FAIL wp_reg2 got %h exp 77", d); else pass_cnt++;
    user_read(4'd3, d);
    total++; if (d !== 8'h66) $display("FAIL wp_reg3 got %h exp 66", d); else pass_cnt++;
    wp_mask = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_collision();
    test_mid_reset();
`ifdef I2C_REGFILE_WRITE_PROTECT_EN
    test_write_protect();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
